// File: rtl/reg_file_rw.sv
// Architectural register file: one write port, two registered read ports under valid/ready, same-cycle write bypass.
// After reset a sequencer clears all NUM_REGS entries (one per cycle) before read requests are accepted.
module reg_file_rw #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_req,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rs_addr,
  input  logic [ADDR_W-1:0] i_rt_addr,
  output logic [DATA_W-1:0] o_rs_data,
  output logic [DATA_W-1:0] o_rt_data,
  output logic              o_rd_valid,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_init_busy
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_clr_cnt;
  logic              r_rd_ready;
  logic              r_init_busy;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_regs [NUM_REGS];

  logic              w_accept;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rs_next;
  logic [DATA_W-1:0] w_rt_next;

  assign w_accept = i_rd_req && (r_state == S_RUN);

  // Single storage write port shared by the clear sequencer and write-back.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = i_wr_addr;
    w_wdata = i_wr_data;
    if (!i_rst) begin
      if (r_state == S_INIT) begin
        w_we    = 1'b1;
        w_waddr = r_clr_cnt[ADDR_W-1:0];
        w_wdata = '0;
      end else if (i_wr_en && (i_wr_addr != '0)) begin
        w_we = 1'b1;
      end
    end
  end

  // A nonzero read address matching the write address implies a nonzero write address.
  always_comb begin
    w_rs_next = r_regs[i_rs_addr];
    w_rt_next = r_regs[i_rt_addr];
    if (i_rs_addr == '0) begin
      w_rs_next = '0;
    end else if (i_wr_en && (i_wr_addr == i_rs_addr)) begin
      w_rs_next = i_wr_data;
    end
    if (i_rt_addr == '0) begin
      w_rt_next = '0;
    end else if (i_wr_en && (i_wr_addr == i_rt_addr)) begin
      w_rt_next = i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_regs[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_INIT;
      r_clr_cnt   <= '0;
      r_rd_ready  <= 1'b0;
      r_init_busy <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
    end else if (r_state == S_INIT) begin
      r_rd_valid <= 1'b0;
      r_clr_cnt  <= r_clr_cnt + CNT_ONE;
      if (r_clr_cnt == LAST_IDX) begin
        r_state     <= S_RUN;
        r_rd_ready  <= 1'b1;
        r_init_busy <= 1'b0;
      end
    end else begin
      r_rd_valid <= w_accept;
      if (w_accept) begin
        r_rs_data <= w_rs_next;
        r_rt_data <= w_rt_next;
      end
    end
  end

  assign o_rd_ready  = r_rd_ready;
  assign o_init_busy = r_init_busy;
  assign o_rd_valid  = r_rd_valid;
  assign o_rs_data   = r_rs_data;
  assign o_rt_data   = r_rt_data;

endmodule

// File: tb/tb_reg_file_rw.sv
// Bench for reg_file_rw: a reference register model feeds an expected-result queue that is
// drained whenever rd_valid pulses; scenario tasks add inline checks on handshake and timing.
module tb_reg_file_rw;

  typedef struct {
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic        rd_ready;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rd_valid;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        init_busy;

  logic [31:0] mdl [32];
  exp_t        exp_q [$];
  int          errors = 0;
  int          checks = 0;

  reg_file_rw #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rd_req    (rd_req),
    .o_rd_ready  (rd_ready),
    .i_rs_addr   (rs_addr),
    .i_rt_addr   (rt_addr),
    .o_rs_data   (rs_data),
    .o_rt_data   (rt_data),
    .o_rd_valid  (rd_valid),
    .i_wr_en     (wr_en),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .o_init_busy (init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every rd_valid pulse consumes exactly one expected entry.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: rs_data=%h rt_data=%h with no pending request", rs_data, rt_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rs_data !== e.rs || rt_data !== e.rt) begin
          errors++;
          $display("FAIL sb_read_data: got rs=%h rt=%h, expected rs=%h rt=%h", rs_data, rt_data, e.rs, e.rt);
        end
      end
    end
  end

  // One clock of stimulus: record what the model expects, then advance past the edge.
  task automatic cyc();
    exp_t e;
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    end else begin
      if (rd_req && rd_ready) begin
        e.rs = (rs_addr == 5'd0) ? 32'h0 : (wr_en && wr_addr == rs_addr) ? wr_data : mdl[rs_addr];
        e.rt = (rt_addr == 5'd0) ? 32'h0 : (wr_en && wr_addr == rt_addr) ? wr_data : mdl[rt_addr];
        exp_q.push_back(e);
      end
      if (wr_en && rd_ready && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd_req = 1'b0;
    wr_en  = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b);
    rd_req = 1'b1; rs_addr = a; rt_addr = b;
    cyc();
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; rd_req = 1'b0; wr_en = 1'b0;
    rs_addr = '0; rt_addr = '0; wr_addr = '0; wr_data = '0;
    cyc(); cyc();
    checks++;
    if (init_busy !== 1'b1 || rd_ready !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: init_busy=%b rd_ready=%b rd_valid=%b, expected 1 0 0", init_busy, rd_ready, rd_valid);
    end
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rs=%h rt=%h, expected 0 0", rs_data, rt_data);
    end
    rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin cyc(); n++; end
    checks++;
    if (n !== 32 || rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init_len: busy cycles=%0d rd_ready=%b, expected 32 and 1", n, rd_ready);
    end
  endtask

  task automatic test_basic();
    wr(5'd3, 32'h12345678);
    wr(5'd7, 32'hCAFEF00D);
    rd(5'd3, 5'd7);
    checks++;
    if (rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: rd_valid=%b one cycle after request, expected 1", rd_valid);
    end
    idle(1);
    checks++;
    if (rd_valid !== 1'b0 || rs_data !== 32'h12345678 || rt_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL basic_hold: rd_valid=%b rs=%h rt=%h, expected 0 12345678 cafef00d", rd_valid, rs_data, rt_data);
    end
  endtask

  task automatic test_bypass();
    wr(5'd9, 32'h11111111);
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000ABCD;
    rd(5'd9, 5'd9);
    wr_en = 1'b0;
    idle(1);
    // Stored value must now be the bypassed write, reading one port against another register.
    rd(5'd9, 5'd3);
    idle(1);
  endtask

  task automatic test_reg0();
    wr(5'd0, 32'hFFFFFFFF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
    rd(5'd0, 5'd7);
    wr_en = 1'b0;
    idle(1);
    checks++;
    if (rs_data !== 32'h0) begin
      errors++;
      $display("FAIL reg0_read: rs_data=%h, expected 00000000", rs_data);
    end
  endtask

  task automatic test_streaming();
    for (int k = 1; k <= 8; k++) wr(5'(k), 32'(k));
    for (int k = 1; k <= 8; k++) begin
      rd_req = 1'b1; rs_addr = 5'(k); rt_addr = 5'(k);
      cyc();
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("FAIL stream_valid_%0d: rd_valid=%b, expected 1", k, rd_valid);
      end
    end
    idle(3);
    checks++;
    if (rd_valid !== 1'b0 || rs_data !== 32'd8 || rt_data !== 32'd8) begin
      errors++;
      $display("FAIL stream_hold: rd_valid=%b rs=%h rt=%h, expected 0 8 8", rd_valid, rs_data, rt_data);
    end
  endtask

  task automatic test_reset_run();
    int n;
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    idle(1);
    rd_req = 1'b1; rs_addr = 5'd5; rt_addr = 5'd5; rst = 1'b1;
    cyc();
    rd_req = 1'b0; rst = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || rs_data !== 32'h0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL run_reset: rd_valid=%b rs=%h init_busy=%b, expected 0 0 1", rd_valid, rs_data, init_busy);
    end
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin cyc(); n++; end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL run_reset_init_len: busy cycles=%0d, expected 32", n);
    end
    rd(5'd5, 5'd5);
    idle(1);
  endtask

  task automatic test_init_reset();
    int n;
    wr(5'd4, 32'h77);
    rst = 1'b1; cyc(); rst = 1'b0;
    idle(10);
    checks++;
    if (init_busy !== 1'b1 || rd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_init_state: init_busy=%b rd_ready=%b, expected 1 0", init_busy, rd_ready);
    end
    rst = 1'b1; cyc(); rst = 1'b0;
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      wr_en = (n == 20); wr_addr = 5'd4; wr_data = 32'h55;
      cyc();
      n++;
    end
    wr_en = 1'b0;
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL mid_init_len: busy cycles=%0d after second reset, expected 32", n);
    end
    rd(5'd4, 5'd4);
    idle(1);
    checks++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      errors++;
      $display("FAIL init_write_dropped: rs=%h rt=%h, expected 0 0", rs_data, rt_data);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    test_reset();
    test_basic();
    test_bypass();
    test_reg0();
    test_streaming();
    test_reset_run();
    test_init_reset();
    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected reads never produced, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
